// File: rtl/sram_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_array_ctrl
// Brief    : Access controller for the compiled SRAM macro. Accepts read and
//            write requests over a valid/ready port, sequences the macro's
//            write-enable and sense-enable timing (one operation in flight),
//            and returns read data through a single-entry response register.
// Revision : 1.0 - initial release
// ============================================================================
module sram_array_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 64,
  parameter int WR_CYCLES    = 1,
  parameter int SENSE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // request port
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  // response port
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  // status
  output logic              wr_done_o,
  output logic              busy_o,
  // macro pins
  output logic [ADDR_W-1:0] arr_addr_o,
  output logic [DATA_W-1:0] arr_din_o,
  input  logic [DATA_W-1:0] arr_dout_i,
  output logic              arr_write_en_o,
  output logic              arr_sense_en_o
);

  localparam int MAX_CYC = (WR_CYCLES > SENSE_CYCLES) ? WR_CYCLES : SENSE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] c_wr_last    = CNT_W'(WR_CYCLES);
  localparam logic [CNT_W-1:0] c_sense_last = CNT_W'(SENSE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_SENSE = 2'd2
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [ADDR_W-1:0]   arr_addr_q;
  logic [DATA_W-1:0]   arr_din_q;
  logic                arr_write_en_q;
  logic                arr_sense_en_q;
  logic                wr_done_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                accept;

  // The response slot is free either when empty or when being drained this cycle.
  assign req_ready_o = (state_q == ST_IDLE) && (!rsp_valid_q || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign cnt_d       = cnt_q + c_cnt_one;

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign wr_done_o      = wr_done_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign arr_addr_o     = arr_addr_q;
  assign arr_din_o      = arr_din_q;
  assign arr_write_en_o = arr_write_en_q;
  assign arr_sense_en_o = arr_sense_en_q;

  // Operation sequencer: accepts requests, times the macro enables, captures read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      arr_addr_q     <= '0;
      arr_din_q      <= '0;
      arr_write_en_q <= 1'b0;
      arr_sense_en_q <= 1'b0;
      wr_done_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      wr_done_q <= 1'b0;

      // A consumed response clears; a read completing below on this edge reloads it.
      if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            arr_addr_q <= req_addr_i;
            arr_din_q  <= req_wdata_i;
            cnt_q      <= c_cnt_one;
            if (req_write_i) begin
              state_q        <= ST_WRITE;
              arr_write_en_q <= 1'b1;
              wr_done_q      <= (WR_CYCLES == 1);
            end else begin
              state_q        <= ST_SENSE;
              arr_sense_en_q <= 1'b1;
            end
          end
        end

        ST_WRITE: begin
          if (cnt_q == c_wr_last) begin
            arr_write_en_q <= 1'b0;
            state_q        <= ST_IDLE;
          end else begin
            cnt_q     <= cnt_d;
            wr_done_q <= (cnt_d == c_wr_last);
          end
        end

        ST_SENSE: begin
          if (cnt_q == c_sense_last) begin
            arr_sense_en_q <= 1'b0;
            rsp_rdata_q    <= arr_dout_i;
            rsp_valid_q    <= 1'b1;
            state_q        <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q        <= ST_IDLE;
          arr_write_en_q <= 1'b0;
          arr_sense_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_array_ctrl
// Brief    : Self-checking bench for sram_array_ctrl with a macro model, a
//            transaction-level reference model and directed plus random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_array_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 64;
  localparam int WR    = 1;
  localparam int SENSE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          wr_done;
  logic          busy;
  logic [AW-1:0] arr_addr;
  logic [DW-1:0] arr_din;
  logic [DW-1:0] arr_dout;
  logic          arr_write_en;
  logic          arr_sense_en;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic rand_rdy = 1'b0;

  sram_array_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WR), .SENSE_CYCLES(SENSE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .wr_done_o(wr_done), .busy_o(busy),
    .arr_addr_o(arr_addr), .arr_din_o(arr_din), .arr_dout_i(arr_dout),
    .arr_write_en_o(arr_write_en), .arr_sense_en_o(arr_sense_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: write on rising edge while write_en, asynchronous read port.
  logic [DW-1:0] macro_mem [1024] = '{default: '0};
  always @(posedge clk) if (arr_write_en) macro_mem[arr_addr] <= arr_din;
  assign arr_dout = macro_mem[arr_addr];

  // Reference model: remaining enable cycles, response slot, latched request.
  logic [DW-1:0] ref_mem [1024] = '{default: '0};
  int            m_wr_left, m_sense_left;
  logic          m_rsp_valid;
  logic [DW-1:0] m_rsp_data, m_pending;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;
  logic          acc_q;
  int            acc_cyc;
  logic          m_idle, m_ready, m_accept;

  assign m_idle   = (m_wr_left == 0) && (m_sense_left == 0);
  assign m_ready  = m_idle && (!m_rsp_valid || rsp_ready);
  assign m_accept = req_valid && m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr_left <= 0; m_sense_left <= 0; m_rsp_valid <= 1'b0;
      m_rsp_data <= '0; m_pending <= '0; m_addr <= '0; m_din <= '0; acc_q <= 1'b0;
    end else begin
      acc_q <= m_accept;
      if (m_accept) begin
        acc_cyc <= cyc; m_addr <= req_addr; m_din <= req_wdata;
      end
      if (m_accept && req_write) begin
        m_wr_left <= WR; ref_mem[req_addr] <= req_wdata;
      end else if (m_wr_left > 0) m_wr_left <= m_wr_left - 1;
      if (m_accept && !req_write) begin
        m_sense_left <= SENSE; m_pending <= ref_mem[req_addr];
      end else if (m_sense_left > 0) m_sense_left <= m_sense_left - 1;
      if (m_sense_left == 1) begin
        m_rsp_valid <= 1'b1; m_rsp_data <= m_pending;
      end else if (m_rsp_valid && rsp_ready) m_rsp_valid <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    chk("req_ready",  64'(req_ready),    64'(m_ready));
    chk("busy",       64'(busy),         64'(!m_idle));
    chk("write_en",   64'(arr_write_en), 64'(m_wr_left > 0));
    chk("wr_done",    64'(wr_done),      64'(m_wr_left == 1));
    chk("sense_en",   64'(arr_sense_en), 64'(m_sense_left > 0));
    chk("rsp_valid",  64'(rsp_valid),    64'(m_rsp_valid));
    chk("rsp_rdata",  rsp_rdata,         m_rsp_data);
    chk("arr_addr",   64'(arr_addr),     64'(m_addr));
    chk("arr_din",    arr_din,           m_din);
    chk("en_overlap", 64'(arr_write_en & arr_sense_en), 64'(0));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a request and hold it until accepted; returns one tick after the accept edge.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    do begin
      if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end while (!acc_q && n < 200);
    if (!acc_q) chk("accept_timeout", 64'(0), 64'(1));
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 50) begin step(); n++; end
    if (!rsp_valid) chk("rsp_timeout", 64'(0), 64'(1));
  endtask

  localparam logic [63:0] c_word1 = 64'hDEADBEEF_01234567;
  localparam logic [63:0] c_word2 = 64'h0BAD_F00D_CAFE_1234;

  initial begin
    int en_seen;
    int t1;
    logic [63:0] d;

    // 1. reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_arr_addr",  64'(arr_addr), 64'(0));
    chk("rst_arr_din",   arr_din, 64'(0));
    chk("rst_rsp_rdata", rsp_rdata, 64'(0));
    chk("rst_flags", 64'({arr_write_en, arr_sense_en, rsp_valid, wr_done, busy}), 64'(0));
    en_seen = 0;
    repeat (20) begin step(); if (arr_write_en || arr_sense_en) en_seen++; end
    chk("idle_no_enables", 64'(en_seen), 64'(0));

    // 2. write 0x005
    issue(1'b1, 10'h005, c_word1);
    chk("wr_en_n1",   64'(arr_write_en), 64'(1));
    chk("wr_done_n1", 64'(wr_done), 64'(1));
    chk("wr_addr",    64'(arr_addr), 64'h005);
    chk("wr_din",     arr_din, c_word1);
    step();
    chk("wr_en_n2",   64'(arr_write_en), 64'(0));

    // 3. read 0x005
    issue(1'b0, 10'h005, '0);
    chk("rd_sense_n1", 64'(arr_sense_en), 64'(1));
    step();
    chk("rd_sense_n2", 64'(arr_sense_en), 64'(1));
    chk("rd_valid_n2", 64'(rsp_valid), 64'(0));
    step();
    chk("rd_valid_n3", 64'(rsp_valid), 64'(1));
    chk("rd_data_n3",  rsp_rdata, c_word1);
    chk("rd_sense_n3", 64'(arr_sense_en), 64'(0));
    step();

    // 4. backpressure, then consume and accept on the same edge
    rsp_ready = 1'b0;
    issue(1'b0, 10'h005, '0);
    wait_rsp();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h3FF;
    repeat (10) begin
      step();
      chk("bp_req_ready", 64'(req_ready), 64'(0));
      chk("bp_rdata", rsp_rdata, c_word1);
    end
    rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("bb_rsp_drained", 64'(rsp_valid), 64'(0));
    chk("bb_sense_en",    64'(arr_sense_en), 64'(1));
    chk("bb_addr",        64'(arr_addr), 64'h3FF);
    wait_rsp();
    step();

    // 5. back-to-back writes at the address extremes
    issue(1'b1, 10'h3FF, c_word2);
    t1 = acc_cyc;
    chk("b2b_addr_hi", 64'(arr_addr), 64'h3FF);
    issue(1'b1, 10'h000, ~c_word2);
    chk("b2b_spacing", 64'(acc_cyc - t1), 64'(2));
    chk("b2b_addr_lo", 64'(arr_addr), 64'h000);
    step();

    // 6. reset during the first sense cycle
    issue(1'b0, 10'h3FF, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sense_en", 64'(arr_sense_en), 64'(0));
    chk("arst_busy",     64'(busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin step(); chk("arst_no_rsp", 64'(rsp_valid), 64'(0)); end
    issue(1'b0, 10'h3FF, '0);
    wait_rsp();
    chk("arst_readback", rsp_rdata, c_word2);
    step();

    // random traffic with random response backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      d = {$urandom, $urandom};
      issue($urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 1023)),
            d);
      repeat ($urandom_range(0, 2)) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    rand_rdy = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
